// File: rtl/cntr8_pkg.sv
// cntr8_pkg: shared encodings for the 8-bit counter and its seek controller.
package cntr8_pkg;
    typedef enum logic [1:0] {
        SEEK_IDLE = 2'd0,
        SEEK_EVAL = 2'd1,
        SEEK_CMD  = 2'd2,
        SEEK_DONE = 2'd3
    } seek_state_t;

    localparam logic MODE_STEP = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_LOAD = 2'd1,
        CNT_INC  = 2'd2,
        CNT_DEC  = 2'd3
    } cnt_op_t;
endpackage

// File: rtl/cla8.sv
// cla8: carry-lookahead adder, sum = a + b + cin (carry out dropped).
module cla8 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum
);
    logic [WIDTH-1:0] g, p, c;
    assign g = a & b;
    assign p = a ^ b;
    assign c[0] = cin;
    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_carry
        assign c[i+1] = g[i] | (p[i] & c[i]);
    end
    assign sum = p ^ c;
endmodule

// File: rtl/cntr8_dir.sv
// cntr8_dir: picks the shorter mod-2^WIDTH direction from cnt to target and the expected next count.
module cntr8_dir #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] cnt,
    output logic             zero,
    output logic             up,
    output logic [WIDTH-1:0] nxt
);
    logic [WIDTH-1:0] diff, step;
    cla8 #(.WIDTH(WIDTH)) u_sub (.a(target), .b(~cnt), .cin(1'b1), .sum(diff));
    // A half-way distance counts as up, so the tie walks with increments.
    assign zero = diff == '0;
    assign up = !diff[WIDTH-1] || diff[WIDTH-2:0] == '0;
    assign step = up ? WIDTH'(1) : '1;
    cla8 #(.WIDTH(WIDTH)) u_nxt (.a(cnt), .b(step), .cin(1'b0), .sum(nxt));
endmodule

// File: rtl/cntr8_seek.sv
// cntr8_seek: drives load/inc/dec into the counter until its output reaches a target, checking every step.
module cntr8_seek
    import cntr8_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_target,
    input  logic [WIDTH-1:0] i_cnt,
    output logic             o_load,
    output logic             o_inc,
    output logic             o_dec,
    output logic [WIDTH-1:0] o_d_in,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [WIDTH-1:0] o_steps
);
    seek_state_t      state;
    logic [WIDTH-1:0] target, exp_cnt, nxt;
    logic             mode, first, zero, up, ok, fin;

    cntr8_dir #(.WIDTH(WIDTH)) u_dir (.target(target), .cnt(i_cnt), .zero(zero), .up(up), .nxt(nxt));

    // The first EVAL has no previous command to verify.
    always_comb begin
        ok = first || i_cnt == exp_cnt;
        fin = state == SEEK_EVAL && (!ok || (mode == MODE_LOAD ? !first : zero));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEEK_IDLE;
            target <= '0;
            exp_cnt <= '0;
            mode <= MODE_STEP;
            first <= 1'b0;
            o_load <= 1'b0;
            o_inc <= 1'b0;
            o_dec <= 1'b0;
            o_d_in <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_err <= 1'b0;
            o_steps <= '0;
        end else begin
            o_load <= 1'b0;
            o_inc <= 1'b0;
            o_dec <= 1'b0;
            o_done <= 1'b0;
            case (state)
                SEEK_IDLE: if (i_start) begin
                    target <= i_target;
                    mode <= i_mode;
                    first <= 1'b1;
                    o_steps <= '0;
                    o_err <= 1'b0;
                    o_busy <= 1'b1;
                    o_d_in <= i_target;
                    state <= SEEK_EVAL;
                end
                SEEK_EVAL: begin
                    first <= 1'b0;
                    if (fin) begin
                        o_done <= 1'b1;
                        o_err <= !ok;
                        o_busy <= 1'b0;
                        o_d_in <= '0;
                        state <= SEEK_DONE;
                    end else if (mode == MODE_LOAD) begin
                        o_load <= 1'b1;
                        exp_cnt <= target;
                        state <= SEEK_CMD;
                    end else begin
                        o_inc <= up;
                        o_dec <= !up;
                        exp_cnt <= nxt;
                        o_steps <= o_steps + WIDTH'(1);
                        state <= SEEK_CMD;
                    end
                end
                SEEK_CMD: state <= SEEK_EVAL;
                default: state <= SEEK_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cntr8_seek.sv
// tb_cntr8_seek: directed checks of cntr8_seek against a behavioural counter with injectable faults.
module tb_cntr8_seek;
    logic       clk = 1'b0, reset = 1'b1, i_start = 1'b0, i_mode = 1'b0;
    logic [7:0] i_target = 8'd0, cnt = 8'd0;
    logic       o_load, o_inc, o_dec, o_busy, o_done, o_err;
    logic [7:0] o_d_in, o_steps;

    int vectors = 0, miscompares = 0;

    logic       set_en = 1'b0, stuck = 1'b0;
    logic [7:0] set_val = 8'd0;
    int         skip_n = 0, inc_seen = 0;

    int         r_done, r_inc, r_dec, r_load;
    logic       r_err, r_multi, r_busy0;
    logic [7:0] r_steps, r_ld, r_d0, r_cnt;

    cntr8_seek dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_mode(i_mode), .i_target(i_target),
        .i_cnt(cnt), .o_load(o_load), .o_inc(o_inc), .o_dec(o_dec), .o_d_in(o_d_in),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_steps(o_steps)
    );

    always #5 clk = ~clk;

    // Counter model: one-cycle registered response, optional stuck / skipped-increment faults.
    always @(posedge clk) begin
        if (set_en) begin
            cnt <= set_val;
            inc_seen <= 0;
        end else if (!stuck) begin
            if (o_load) cnt <= o_d_in;
            else if (o_inc) begin
                inc_seen <= inc_seen + 1;
                if (!(skip_n != 0 && inc_seen == skip_n - 1)) cnt <= cnt + 8'd1;
            end else if (o_dec) cnt <= cnt - 8'd1;
        end
    end

    task automatic preset(input logic [7:0] v);
        @(negedge clk);
        set_en = 1'b1;
        set_val = v;
        @(negedge clk);
        set_en = 1'b0;
    endtask

    task automatic run_op(input logic mode, input logic [7:0] tgt, input int poke);
        r_done = -1; r_inc = 0; r_dec = 0; r_load = 0; r_ld = 8'd0; r_multi = 1'b0;
        r_err = 1'bx; r_steps = 8'hxx;
        @(negedge clk);
        i_start = 1'b1;
        i_mode = mode;
        i_target = tgt;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_target = ~tgt;
        r_busy0 = o_busy;
        r_d0 = o_d_in;
        for (int e = 1; e <= 400; e++) begin
            @(posedge clk);
            #1;
            i_start = (e == poke);
            i_mode = ~mode;
            r_inc += int'(o_inc);
            r_dec += int'(o_dec);
            r_load += int'(o_load);
            if (o_load) r_ld = o_d_in;
            if ($countones({o_load, o_inc, o_dec}) > 1) r_multi = 1'b1;
            if (o_done) begin
                r_done = e;
                r_err = o_err;
                r_steps = o_steps;
                break;
            end
        end
        i_start = 1'b0;
        r_cnt = cnt;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({o_load, o_inc, o_dec, o_busy, o_done, o_err, o_d_in, o_steps} !== 22'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", {o_load, o_inc, o_dec, o_busy, o_done, o_err, o_d_in, o_steps});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_step;
        preset(8'd10);
        run_op(1'b0, 8'd13, 0);
        vectors++; if (r_done !== 7) begin miscompares++; $display("FAIL step_done_edge: got %0d want 7", r_done); end
        vectors++; if (r_inc !== 3 || r_dec !== 0) begin miscompares++; $display("FAIL step_pulses: got inc=%0d dec=%0d want inc=3 dec=0", r_inc, r_dec); end
        vectors++; if (r_steps !== 8'd3 || r_err !== 1'b0) begin miscompares++; $display("FAIL step_steps_err: got %0d/%b want 3/0", r_steps, r_err); end
        vectors++; if (r_busy0 !== 1'b1 || r_d0 !== 8'd13) begin miscompares++; $display("FAIL step_busy_din: got %b/%0d want 1/13", r_busy0, r_d0); end
        vectors++; if (r_cnt !== 8'd13 || r_multi !== 1'b0) begin miscompares++; $display("FAIL step_final_cnt: got %0d multi=%b want 13 multi=0", r_cnt, r_multi); end
    endtask

    task automatic test_wrap;
        preset(8'd250);
        run_op(1'b0, 8'd4, 0);
        vectors++; if (r_done !== 21 || r_inc !== 10 || r_dec !== 0) begin miscompares++; $display("FAIL wrap_up: got edge=%0d inc=%0d dec=%0d want 21/10/0", r_done, r_inc, r_dec); end
        vectors++; if (r_cnt !== 8'd4 || r_err !== 1'b0) begin miscompares++; $display("FAIL wrap_up_cnt: got %0d err=%b want 4 err=0", r_cnt, r_err); end
        preset(8'd4);
        run_op(1'b0, 8'd250, 0);
        vectors++; if (r_done !== 21 || r_inc !== 0 || r_dec !== 10) begin miscompares++; $display("FAIL wrap_down: got edge=%0d inc=%0d dec=%0d want 21/0/10", r_done, r_inc, r_dec); end
        vectors++; if (r_cnt !== 8'd250 || r_steps !== 8'd10) begin miscompares++; $display("FAIL wrap_down_cnt: got %0d steps=%0d want 250/10", r_cnt, r_steps); end
    endtask

    task automatic test_tie;
        preset(8'd0);
        run_op(1'b0, 8'd128, 0);
        vectors++; if (r_done !== 257 || r_inc !== 128 || r_dec !== 0) begin miscompares++; $display("FAIL tie_128: got edge=%0d inc=%0d dec=%0d want 257/128/0", r_done, r_inc, r_dec); end
        vectors++; if (r_steps !== 8'd128 || r_cnt !== 8'd128) begin miscompares++; $display("FAIL tie_128_steps: got steps=%0d cnt=%0d want 128/128", r_steps, r_cnt); end
        preset(8'd0);
        run_op(1'b0, 8'd129, 0);
        vectors++; if (r_done !== 255 || r_inc !== 0 || r_dec !== 127) begin miscompares++; $display("FAIL tie_129: got edge=%0d inc=%0d dec=%0d want 255/0/127", r_done, r_inc, r_dec); end
        preset(8'd77);
        run_op(1'b0, 8'd77, 0);
        vectors++; if (r_done !== 1 || r_steps !== 8'd0 || r_inc + r_dec !== 0) begin miscompares++; $display("FAIL tie_equal: got edge=%0d steps=%0d cmds=%0d want 1/0/0", r_done, r_steps, r_inc + r_dec); end
    endtask

    task automatic test_load;
        preset(8'd3);
        run_op(1'b1, 8'h5A, 0);
        vectors++; if (r_done !== 3 || r_err !== 1'b0) begin miscompares++; $display("FAIL load_ok: got edge=%0d err=%b want 3/0", r_done, r_err); end
        vectors++; if (r_load !== 1 || r_ld !== 8'h5A || r_inc + r_dec !== 0) begin miscompares++; $display("FAIL load_pulse: got loads=%0d data=%h steps_cmds=%0d want 1/5a/0", r_load, r_ld, r_inc + r_dec); end
        vectors++; if (r_cnt !== 8'h5A) begin miscompares++; $display("FAIL load_cnt: got %h want 5a", r_cnt); end
        preset(8'd0);
        stuck = 1'b1;
        run_op(1'b1, 8'h5A, 0);
        stuck = 1'b0;
        vectors++; if (r_done !== 3 || r_err !== 1'b1) begin miscompares++; $display("FAIL load_stuck: got edge=%0d err=%b want 3/1", r_done, r_err); end
    endtask

    task automatic test_skip_and_busy_start;
        preset(8'd0);
        skip_n = 2;
        run_op(1'b0, 8'd5, 2);
        skip_n = 0;
        vectors++; if (r_done !== 5 || r_err !== 1'b1) begin miscompares++; $display("FAIL skip_err: got edge=%0d err=%b want 5/1", r_done, r_err); end
        vectors++; if (r_steps !== 8'd2 || r_load !== 0) begin miscompares++; $display("FAIL skip_steps: got steps=%0d loads=%0d want 2/0", r_steps, r_load); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (o_err !== 1'b1 || o_done !== 1'b0 || o_busy !== 1'b0) begin miscompares++; $display("FAIL err_hold_idle: got err=%b done=%b busy=%b want 1/0/0", o_err, o_done, o_busy); end
        vectors++; if (o_steps !== 8'd2 || cnt !== 8'd1) begin miscompares++; $display("FAIL busy_start_ignored: got steps=%0d cnt=%0d want 2/1", o_steps, cnt); end
    endtask

    task automatic test_reset_mid;
        int seen_done;
        preset(8'd10);
        @(negedge clk);
        i_start = 1'b1;
        i_mode = 1'b0;
        i_target = 8'd200;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({o_load, o_inc, o_dec, o_busy, o_done, o_err, o_d_in, o_steps} !== 22'd0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %h want 0", {o_load, o_inc, o_dec, o_busy, o_done, o_err, o_d_in, o_steps});
        end
        seen_done = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            seen_done += int'(o_done);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            seen_done += int'(o_done) + int'(o_busy);
        end
        vectors++; if (seen_done !== 0) begin miscompares++; $display("FAIL reset_mid_no_done: got %0d want 0", seen_done); end
        preset(8'd10);
        run_op(1'b0, 8'd12, 0);
        vectors++; if (r_done !== 5 || r_err !== 1'b0 || r_steps !== 8'd2) begin miscompares++; $display("FAIL reset_mid_restart: got edge=%0d err=%b steps=%0d want 5/0/2", r_done, r_err, r_steps); end
    endtask

    initial begin
        test_reset;
        test_step;
        test_wrap;
        test_tie;
        test_load;
        test_skip_and_busy_start;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
